// File: rtl/pkg_ft601_ctrl_defines.sv
// Shared FT601 controller definitions: bus sizing, memory-init FSM states and
// the even-parity helper used by the byte-enable RAM.
package pkg_ft601_ctrl_defines;

  localparam int WIDTH_DATA  = 32;
  localparam int CNT_CHANNLS = 4;

  // Widest lane the parity helper accepts; narrower lanes are zero-extended.
  localparam int LANE_MAX = 64;

  typedef enum logic {
    ST_CLR,
    ST_RUN
  } mem_init_st_t;

  // Even parity: the returned bit makes lane plus parity carry an even number of ones.
  function automatic logic lane_par(input logic [LANE_MAX-1:0] lane);
    return ^lane;
  endfunction

endpackage

// File: rtl/mem_sp_be_array.sv
// Raw single-port storage with per-lane write enables and combinational read.
// Pure storage; the sweep, muxing and parity live in the wrapper above it.
module mem_sp_be_array #(
  parameter int AW      = 12,
  parameter int N_LANES = 4,
  parameter int LANE_W  = 9
) (
  input  logic                      clk,
  input  logic [N_LANES-1:0]        we,
  input  logic [AW-1:0]             addr,
  input  logic [N_LANES*LANE_W-1:0] wdata,
  output logic [N_LANES*LANE_W-1:0] rdata
);

  logic [N_LANES*LANE_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_LANES; i++) begin
      if (we[i]) begin
        mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_sp_be_init.sv
// Single-port RAM wrapper: byte-lane writes, clear sweep after reset/CLR,
// per-lane even parity with error flag, and a 1- or 2-cycle read pipeline.
//
//  state  | meaning
//  -------+--------------------------------------------------------------
//  ST_CLR | sweep writes INIT_VAL to one address per cycle, RDY = 0
//  ST_RUN | sweep done, user reads/writes accepted, RDY = 1
module mem_sp_be_init
  import pkg_ft601_ctrl_defines::*;
#(
  parameter int                                          T_MSZ      = 12,
  parameter int                                          WIDTH_DATA = pkg_ft601_ctrl_defines::WIDTH_DATA,
  parameter int                                          N_LANES    = CNT_CHANNLS,
  parameter int                                          RD_LAT     = 1,
  parameter logic [WIDTH_DATA-1:0]                       INIT_VAL   = '0,
  parameter bit                                          PAR_EN     = 1'b1
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  CE,
  input  logic [N_LANES-1:0]    WE,
  input  logic [T_MSZ-1:0]      A,
  input  logic [WIDTH_DATA-1:0] D,
  input  logic                  ERR_INJ,
  input  logic                  CLR,
  output logic [WIDTH_DATA-1:0] Q,
  output logic                  Q_VLD,
  output logic [N_LANES-1:0]    PERR,
  output logic                  RDY
);

  localparam int LW    = WIDTH_DATA / N_LANES;
  localparam int PW    = PAR_EN ? 1 : 0;
  localparam int LWS   = LW + PW;
  localparam int ARR_W = N_LANES * LWS;

  mem_init_st_t     st;
  logic [T_MSZ-1:0] sweep_addr;
  logic             rdy_q;

  logic acc, wr_acc, rd_acc;

  logic [N_LANES-1:0]    arr_we;
  logic [T_MSZ-1:0]      arr_addr;
  logic [ARR_W-1:0]      arr_wdata, arr_rdata, init_w, usr_w;
  logic [WIDTH_DATA-1:0] rd_data;
  logic [N_LANES-1:0]    perr_rd;

  logic                  v1;
  logic [WIDTH_DATA-1:0] q1;
  logic [N_LANES-1:0]    p1;

  // CLR and rst win over a user access in the same cycle.
  assign acc    = CE & rdy_q & ~CLR & ~rst;
  assign wr_acc = acc & (|WE);
  assign rd_acc = acc & ~(|WE);

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    logic [LW-1:0] init_l, d_l, r_l;

    assign init_l = INIT_VAL[g*LW +: LW];
    assign d_l    = D[g*LW +: LW];
    assign r_l    = arr_rdata[g*LWS +: LW];
    assign rd_data[g*LW +: LW] = r_l;

    if (PAR_EN) begin : g_par
      assign init_w[g*LWS +: LWS] = {lane_par(LANE_MAX'(init_l)), init_l};
      assign usr_w[g*LWS +: LWS]  = {lane_par(LANE_MAX'(d_l)) ^ ERR_INJ, d_l};
      assign perr_rd[g]           = arr_rdata[g*LWS + LW] ^ lane_par(LANE_MAX'(r_l));
    end else begin : g_nopar
      assign init_w[g*LWS +: LWS] = init_l;
      assign usr_w[g*LWS +: LWS]  = d_l;
      assign perr_rd[g]           = 1'b0;
    end
  end

  always_comb begin
    arr_addr  = A;
    arr_wdata = usr_w;
    arr_we    = '0;
    if (st == ST_CLR) begin
      arr_addr  = sweep_addr;
      arr_wdata = init_w;
      arr_we    = CLR ? '0 : '1;
    end else if (wr_acc) begin
      arr_we = WE;
    end
  end

  mem_sp_be_array #(
    .AW      (T_MSZ),
    .N_LANES (N_LANES),
    .LANE_W  (LWS)
  ) u_array (
    .clk   (CLK),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge CLK) begin
    if (rst) begin
      st         <= ST_CLR;
      sweep_addr <= '0;
      rdy_q      <= 1'b0;
    end else if (CLR) begin
      st         <= ST_CLR;
      sweep_addr <= '0;
      rdy_q      <= 1'b0;
    end else if (st == ST_CLR) begin
      sweep_addr <= sweep_addr + T_MSZ'(1);
      if (sweep_addr == '1) begin
        st    <= ST_RUN;
        rdy_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      v1 <= 1'b0;
      q1 <= '0;
      p1 <= '0;
    end else begin
      v1 <= rd_acc;
      p1 <= rd_acc ? perr_rd : '0;
      if (rd_acc) q1 <= rd_data;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic                  v2;
    logic [WIDTH_DATA-1:0] q2;
    logic [N_LANES-1:0]    p2;
    logic                  adv;

    // A CLR arriving while a read sits in stage 1 kills its strobe.
    assign adv = v1 & ~CLR;

    always_ff @(posedge CLK) begin
      if (rst) begin
        v2 <= 1'b0;
        q2 <= '0;
        p2 <= '0;
      end else begin
        v2 <= adv;
        p2 <= adv ? p1 : '0;
        if (adv) q2 <= q1;
      end
    end

    assign Q     = q2;
    assign Q_VLD = v2;
    assign PERR  = p2;
  end else begin : g_lat1
    assign Q     = q1;
    assign Q_VLD = v1;
    assign PERR  = p1;
  end

  assign RDY = rdy_q;

endmodule

// File: tb/tb_mem_sp_be_init.sv
// Bench for mem_sp_be_init: RD_LAT=1 and RD_LAT=2 instances share stimulus and
// are compared every cycle against a word/lane-level memory model.
module tb_mem_sp_be_init;

  logic        clk = 1'b0;
  logic        rst, ce, inj, clr;
  logic [3:0]  we, a;
  logic [31:0] d;

  logic [31:0] q1, q2;
  logic        vld1, vld2, rdy1, rdy2;
  logic [3:0]  perr1, perr2;

  always #5 clk = ~clk;

  mem_sp_be_init #(.T_MSZ(4), .WIDTH_DATA(32), .N_LANES(4), .RD_LAT(1),
                   .INIT_VAL(32'h0), .PAR_EN(1'b1)) d1 (
    .CLK(clk), .rst(rst), .CE(ce), .WE(we), .A(a), .D(d), .ERR_INJ(inj), .CLR(clr),
    .Q(q1), .Q_VLD(vld1), .PERR(perr1), .RDY(rdy1));

  mem_sp_be_init #(.T_MSZ(4), .WIDTH_DATA(32), .N_LANES(4), .RD_LAT(2),
                   .INIT_VAL(32'h0), .PAR_EN(1'b1)) d2 (
    .CLK(clk), .rst(rst), .CE(ce), .WE(we), .A(a), .D(d), .ERR_INJ(inj), .CLR(clr),
    .Q(q2), .Q_VLD(vld2), .PERR(perr2), .RDY(rdy2));

  typedef struct {
    int          due;
    logic [31:0] data;
    logic [3:0]  bad;
  } rd_t;

  rd_t         pq1[$], pq2[$];
  logic [31:0] m_mem [16];
  logic [3:0]  m_bad [16];
  bit          m_rdy;
  int          m_cnt, cyc_n;
  logic [31:0] lastq1, lastq2;
  logic [3:0]  obs_perr1, obs_perr2;
  int          obs_str1, obs_str2;
  int          total, bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc_n, got, exp);
    end
  endtask

  task automatic cancel_pending();
    for (int i = pq1.size() - 1; i >= 0; i--) if (pq1[i].due >= cyc_n) pq1.delete(i);
    for (int i = pq2.size() - 1; i >= 0; i--) if (pq2[i].due >= cyc_n) pq2.delete(i);
  endtask

  // Model: RDY comes 16 edges after the last rst/CLR; memory reads as INIT then.
  task automatic model_edge(input logic ce_i, input logic [3:0] we_i, input logic [3:0] a_i,
                            input logic [31:0] d_i, input logic inj_i, input logic clr_i,
                            input logic rst_i);
    cyc_n++;
    if (rst_i || clr_i) begin
      cancel_pending();
      m_rdy = 0;
      m_cnt = 0;
      if (rst_i) begin
        lastq1 = '0;
        lastq2 = '0;
      end
    end else if (!m_rdy) begin
      m_cnt++;
      if (m_cnt == 16) begin
        m_rdy = 1;
        for (int i = 0; i < 16; i++) begin
          m_mem[i] = '0;
          m_bad[i] = '0;
        end
      end
    end else if (ce_i) begin
      if (we_i != 4'b0) begin
        for (int l = 0; l < 4; l++) begin
          if (we_i[l]) begin
            m_mem[a_i][l*8 +: 8] = d_i[l*8 +: 8];
            m_bad[a_i][l]        = inj_i;
          end
        end
      end else begin
        pq1.push_back('{cyc_n,     m_mem[a_i], m_bad[a_i]});
        pq2.push_back('{cyc_n + 1, m_mem[a_i], m_bad[a_i]});
      end
    end
  endtask

  task automatic observe();
    rd_t e;
    chk("rdy1", {31'b0, rdy1}, {31'b0, m_rdy});
    chk("rdy2", {31'b0, rdy2}, {31'b0, m_rdy});
    if (vld1 === 1'b1) begin obs_str1++; obs_perr1 = perr1; end
    if (vld2 === 1'b1) begin obs_str2++; obs_perr2 = perr2; end
    if (pq1.size() > 0 && pq1[0].due == cyc_n) begin
      e = pq1.pop_front();
      chk("vld1", {31'b0, vld1}, 32'd1);
      chk("q1", q1, e.data);
      chk("perr1", {28'b0, perr1}, {28'b0, e.bad});
      lastq1 = e.data;
    end else begin
      chk("vld1_idle", {31'b0, vld1}, 32'd0);
      chk("q1_hold", q1, lastq1);
      chk("perr1_idle", {28'b0, perr1}, 32'd0);
    end
    if (pq2.size() > 0 && pq2[0].due == cyc_n) begin
      e = pq2.pop_front();
      chk("vld2", {31'b0, vld2}, 32'd1);
      chk("q2", q2, e.data);
      chk("perr2", {28'b0, perr2}, {28'b0, e.bad});
      lastq2 = e.data;
    end else begin
      chk("vld2_idle", {31'b0, vld2}, 32'd0);
      chk("q2_hold", q2, lastq2);
      chk("perr2_idle", {28'b0, perr2}, 32'd0);
    end
  endtask

  task automatic step(input logic ce_i, input logic [3:0] we_i, input logic [3:0] a_i,
                      input logic [31:0] d_i, input logic inj_i, input logic clr_i,
                      input logic rst_i);
    ce = ce_i; we = we_i; a = a_i; d = d_i; inj = inj_i; clr = clr_i; rst = rst_i;
    @(posedge clk);
    model_edge(ce_i, we_i, a_i, d_i, inj_i, clr_i, rst_i);
    @(negedge clk);
    observe();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [3:0] a_i, input logic [3:0] we_i, input logic [31:0] d_i,
                    input logic inj_i);
    step(1'b1, we_i, a_i, d_i, inj_i, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [3:0] a_i);
    step(1'b1, 4'h0, a_i, $urandom, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_rdy(input int already, input string tag);
    int n;
    n = already;
    while (rdy1 !== 1'b1 && n < 40) begin
      idle(1);
      n++;
    end
    chk(tag, n, 16);
  endtask

  initial begin
    int s1, s2;
    total = 0; bad = 0; cyc_n = 0; m_rdy = 0; m_cnt = 0;
    lastq1 = '0; lastq2 = '0; obs_str1 = 0; obs_str2 = 0;
    obs_perr1 = '0; obs_perr2 = '0;
    ce = 0; we = 0; a = 0; d = 0; inj = 0; clr = 0; rst = 1;

    // reset state
    step(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("rst_q", q1, 32'h0);
    chk("rst_rdy", {31'b0, rdy1}, 32'd0);

    // 1: sweep length and cleared contents
    wait_rdy(0, "rdy_lat");
    for (int i = 0; i < 16; i++) rd(4'(i));
    idle(2);

    // 2: byte-lane merge
    wr(4'd3, 4'b1111, 32'hA5A5_1234, 1'b0);
    wr(4'd3, 4'b0101, 32'hFFFF_FFFF, 1'b0);
    rd(4'd3);
    idle(2);
    chk("t2_q1", q1, 32'hA5FF_12FF);
    chk("t2_q2", q2, 32'hA5FF_12FF);

    // 3: back-to-back reads
    wr(4'd1, 4'hF, 32'h1111_0001, 1'b0);
    wr(4'd2, 4'hF, 32'h2222_0002, 1'b0);
    s2 = obs_str2;
    rd(4'd1); rd(4'd2); rd(4'd3);
    idle(3);
    chk("t3_strobes2", obs_str2 - s2, 3);
    chk("t3_last2", q2, 32'hA5FF_12FF);

    // 4: injected parity error on lane 1
    wr(4'd5, 4'b0010, $urandom, 1'b1);
    rd(4'd5);
    idle(2);
    chk("t4_perr1", {28'b0, obs_perr1}, 32'b0010);
    chk("t4_perr2", {28'b0, obs_perr2}, 32'b0010);

    // 5: CLR right after a read
    s1 = obs_str1; s2 = obs_str2;
    rd(4'd3);
    step(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("t5_strobes2", obs_str2 - s2, 0);
    chk("t5_strobes1", obs_str1 - s1, 1);
    wait_rdy(0, "t5_rdy_lat");
    rd(4'd3);
    idle(2);
    chk("t5_a3", q1, 32'h0);

    // 6: rst at sweep address 7, stray accesses while not ready
    wr(4'd2, 4'hF, 32'hDEAD_BEEF, 1'b0);
    step(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    idle(7);
    step(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(10);
    s1 = obs_str1;
    wr(4'd2, 4'hF, 32'h5A5A_C3C3, 1'b0);
    rd(4'd2);
    wait_rdy(12, "t6_rdy_lat");
    chk("t6_stray_vld", obs_str1 - s1, 0);
    rd(4'd2);
    idle(2);
    chk("t6_a2", q1, 32'h0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic       ce_r, inj_r, clr_r, rst_r;
      logic [3:0] we_r;
      ce_r  = ($urandom_range(0, 2) != 0);
      we_r  = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
      inj_r = ($urandom_range(0, 7) == 0);
      clr_r = ($urandom_range(0, 59) == 0);
      rst_r = ($urandom_range(0, 199) == 0);
      step(ce_r, we_r, 4'($urandom), $urandom, inj_r, clr_r, rst_r);
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
